// File: rtl/rgb_pkg.sv
// Shared constants, state encoding and colour-rotation helper for the RGB PWM blocks.
package rgb_pkg;

    localparam logic [2:0] CH_R = 3'b001;
    localparam logic [2:0] CH_G = 3'b010;
    localparam logic [2:0] CH_B = 3'b100;

    localparam int PWM_MAX = 9;
    localparam int COL_MAX = 10;

    typedef enum logic [1:0] {
        MANUAL,
        AUTO_UP,
        AUTO_DN
    } seq_state_t;

    // R -> G -> B -> R as a left rotate of the hot-one select
    function automatic logic [2:0] next_colour(input logic [2:0] sel);
        return {sel[1:0], sel[2]};
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, 0..9 main counter and a one-cycle wrap pulse.
module pwm_timebase
    import rgb_pkg::*;
#(
    parameter int PRESC_MAX = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] main_cnt,
    output logic       pwm_wrap
);

    localparam int PW = $clog2(PRESC_MAX + 1);

    logic [PW-1:0] presc;

    // pwm_wrap is high in the first cycle that main_cnt reads 0 after 9
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            main_cnt <= '0;
            pwm_wrap <= 1'b0;
        end else begin
            pwm_wrap <= 1'b0;
            if (presc == PW'(PRESC_MAX)) begin
                presc <= '0;
                if (main_cnt == 4'(PWM_MAX)) begin
                    main_cnt <= '0;
                    pwm_wrap <= 1'b1;
                end else begin
                    main_cnt <= main_cnt + 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// RGB LED sequencer: owns the PWM timebase and colour select, turns button pulses
// into slice step/direction controls and runs the automatic fade in AUTO mode.
module rgb_pwm_sequencer
    import rgb_pkg::*;
#(
    parameter int PRESC_MAX = 999,
    parameter int FADE_DIV  = 4
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       BTN_SEL,
    input  logic       BTN_STEP,
    input  logic       BTN_DIR,
    input  logic       BTN_MODE,
    output logic [3:0] MAIN_CNT,
    output logic [2:0] H1,
    output logic       INCR,
    output logic       DIR_CNT,
    output logic       COL_CLR,
    output logic       MODE
);

    localparam int FW = $clog2(FADE_DIV + 1);

    seq_state_t    state;
    logic [3:0]    step_cnt;
    logic [FW-1:0] fade_div;
    logic          pwm_wrap;

    pwm_timebase #(
        .PRESC_MAX(PRESC_MAX)
    ) u_timebase (
        .clk     (CLK),
        .rst_n   (CLR_N),
        .main_cnt(MAIN_CNT),
        .pwm_wrap(pwm_wrap)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state    <= MANUAL;
            H1       <= CH_R;
            INCR     <= 1'b0;
            DIR_CNT  <= 1'b0;
            COL_CLR  <= 1'b0;
            MODE     <= 1'b0;
            step_cnt <= '0;
            fade_div <= '0;
        end else begin
            INCR    <= 1'b0;
            COL_CLR <= 1'b0;
            if (BTN_MODE) begin
                if (state == MANUAL) begin
                    state    <= AUTO_UP;
                    MODE     <= 1'b1;
                    COL_CLR  <= 1'b1;
                    H1       <= CH_R;
                    DIR_CNT  <= 1'b0;
                    step_cnt <= '0;
                    fade_div <= '0;
                end else begin
                    state <= MANUAL;
                    MODE  <= 1'b0;
                end
            end else begin
                case (state)
                    MANUAL: begin
                        if (BTN_SEL) begin
                            H1 <= next_colour(H1);
                        end else if (BTN_STEP) begin
                            INCR <= 1'b1;
                        end
                        if (BTN_DIR) begin
                            DIR_CNT <= ~DIR_CNT;
                        end
                    end
                    default: begin
                        if (pwm_wrap) begin
                            if (fade_div == FW'(FADE_DIV - 1)) begin
                                fade_div <= '0;
                                INCR     <= 1'b1;
                                step_cnt <= step_cnt + 1'b1;
                            end else begin
                                fade_div <= fade_div + 1'b1;
                            end
                        end
                        // Turn around one cycle after the 10th step so DIR_CNT/H1
                        // never move while INCR is high.
                        if (INCR && step_cnt == 4'(COL_MAX)) begin
                            step_cnt <= '0;
                            if (state == AUTO_UP) begin
                                state   <= AUTO_DN;
                                DIR_CNT <= 1'b1;
                            end else begin
                                state   <= AUTO_UP;
                                DIR_CNT <= 1'b0;
                                H1      <= next_colour(H1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Self-checking bench for rgb_pwm_sequencer: directed steps plus random manual
// button traffic, compared each cycle against an arithmetic reference model.
module tb_rgb_pwm_sequencer;

    localparam int P      = 1;
    localparam int F      = 2;
    localparam int PERIOD = 10 * (P + 1);

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_dir = 1'b0;
    logic       btn_mode = 1'b0;
    logic [3:0] main_cnt;
    logic [2:0] h1;
    logic       incr;
    logic       dir_cnt;
    logic       col_clr;
    logic       mode;

    always #5 clk = ~clk;

    rgb_pwm_sequencer #(
        .PRESC_MAX(P),
        .FADE_DIV (F)
    ) dut (
        .CLK     (clk),
        .CLR_N   (clr_n),
        .BTN_SEL (btn_sel),
        .BTN_STEP(btn_step),
        .BTN_DIR (btn_dir),
        .BTN_MODE(btn_mode),
        .MAIN_CNT(main_cnt),
        .H1      (h1),
        .INCR    (incr),
        .DIR_CNT (dir_cnt),
        .COL_CLR (col_clr),
        .MODE    (mode)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int k;            // clock edges since reset release
    bit m_auto, m_dn, m_dir, m_incr, m_clr, m_prev_incr;
    int m_col, m_steps, m_wraps;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; m_auto = 0; m_dn = 0; m_dir = 0; m_incr = 0; m_clr = 0;
        m_prev_incr = 0; m_col = 0; m_steps = 0; m_wraps = 0;
    endtask

    task automatic model_edge(input bit s, input bit st, input bit d, input bit m);
        bit wrap;
        wrap = (k > 0) && (k % PERIOD == 0);
        k++;
        m_prev_incr = m_incr;
        m_incr = 0;
        m_clr  = 0;
        if (m) begin
            if (!m_auto) begin
                m_auto = 1; m_clr = 1; m_col = 0; m_dir = 0; m_dn = 0;
                m_steps = 0; m_wraps = 0;
            end else begin
                m_auto = 0;
            end
        end else if (!m_auto) begin
            if (s) m_col = (m_col + 1) % 3;
            else if (st) m_incr = 1;
            if (d) m_dir = !m_dir;
        end else begin
            if (m_prev_incr && m_steps == 10) begin
                m_steps = 0;
                if (!m_dn) begin
                    m_dn = 1; m_dir = 1;
                end else begin
                    m_dn = 0; m_dir = 0; m_col = (m_col + 1) % 3;
                end
            end
            if (wrap) begin
                m_wraps++;
                if (m_wraps == F) begin
                    m_wraps = 0; m_incr = 1; m_steps++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("main_cnt", 32'(main_cnt), 32'((k / (P + 1)) % 10));
        check("h1", 32'(h1), 32'(1 << m_col));
        check("incr", 32'(incr), 32'(m_incr));
        check("dir_cnt", 32'(dir_cnt), 32'(m_dir));
        check("col_clr", 32'(col_clr), 32'(m_clr));
        check("mode", 32'(mode), 32'(m_auto));
    endtask

    // Hold the given buttons for exactly one rising edge, then compare at +1.
    task automatic tick(input bit s, input bit st, input bit d, input bit m);
        btn_sel = s; btn_step = st; btn_dir = d; btn_mode = m;
        @(posedge clk);
        model_edge(s, st, d, m);
        #1;
        btn_sel = 0; btn_step = 0; btn_dir = 0; btn_mode = 0;
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_main_cnt"}, 32'(main_cnt), 32'd0);
        check({tag, "_h1"}, 32'(h1), 32'b001);
        check({tag, "_incr"}, 32'(incr), 32'd0);
        check({tag, "_dir_cnt"}, 32'(dir_cnt), 32'd0);
        check({tag, "_col_clr"}, 32'(col_clr), 32'd0);
        check({tag, "_mode"}, 32'(mode), 32'd0);
    endtask

    initial begin
        int n, n_up, n_dn, guard;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        clr_n = 1'b1;
        model_reset();

        // Timebase: one full PWM period returns MAIN_CNT to 0
        for (int i = 0; i < PERIOD; i++) tick(0, 0, 0, 0);
        check("tb_wrap_zero", 32'(main_cnt), 32'd0);
        check("tb_h1_idle", 32'(h1), 32'b001);

        // Colour select rotation
        tick(1, 0, 0, 0); check("sel1", 32'(h1), 32'b010);
        tick(1, 0, 0, 0); check("sel2", 32'(h1), 32'b100);
        tick(1, 0, 0, 0); check("sel3", 32'(h1), 32'b001);

        // Single step strobe
        tick(0, 1, 0, 0); check("step_incr", 32'(incr), 32'd1);
        tick(0, 0, 0, 0); check("step_incr_once", 32'(incr), 32'd0);

        // SEL wins over STEP
        tick(1, 1, 0, 0);
        check("selstep_h1", 32'(h1), 32'b010);
        check("selstep_incr", 32'(incr), 32'd0);

        // DIR and STEP together
        tick(0, 1, 1, 0);
        check("dirstep_dir", 32'(dir_cnt), 32'd1);
        check("dirstep_incr", 32'(incr), 32'd1);

        // Random manual traffic
        for (int i = 0; i < 200; i++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0, 1'b0);

        // AUTO entry
        tick(0, 0, 0, 1);
        check("auto_col_clr", 32'(col_clr), 32'd1);
        check("auto_mode", 32'(mode), 32'd1);
        check("auto_h1", 32'(h1), 32'b001);
        check("auto_dir", 32'(dir_cnt), 32'd0);

        n = 0; n_up = 0; n_dn = 0; guard = 0;
        while (n < 20 && guard < 3000) begin
            tick(0, 0, 0, 0);
            guard++;
            if (incr === 1'b1) begin
                n++;
                if (dir_cnt === 1'b1) n_dn++; else n_up++;
            end
        end
        check("fade_incr_total", 32'(n), 32'd20);
        check("fade_incr_up", 32'(n_up), 32'd10);
        check("fade_incr_dn", 32'(n_dn), 32'd10);
        check("fade_h1_hold", 32'(h1), 32'b001);
        tick(0, 0, 0, 0);
        check("fade_h1_rot", 32'(h1), 32'b010);
        check("fade_rot_no_incr", 32'(incr), 32'd0);

        // Reach AUTO_DN after 5 steps, then MODE+STEP together
        n = 0; guard = 0;
        while (n < 15 && guard < 3000) begin
            tick(0, 0, 0, 0);
            guard++;
            if (incr === 1'b1) n++;
        end
        check("dn5_reached", 32'(n), 32'd15);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 1);
        check("exit_mode", 32'(mode), 32'd0);
        check("exit_incr", 32'(incr), 32'd0);
        check("exit_h1", 32'(h1), 32'b010);
        check("exit_dir", 32'(dir_cnt), 32'd1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);

        // Reset mid-fade
        tick(0, 0, 0, 1);
        for (int i = 0; i < 100; i++) tick(0, 0, 0, 0);
        #3;
        clr_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        model_reset();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick(0, 0, 0, 0);
            if (incr !== 1'b0) n++;
        end
        check("post_reset_no_incr", 32'(n), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
